// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter
// Purpose  : Round-robin arbiter that shares one 16-way 1-bit multiplexer
//            among 16 requesters. One owner at a time, with an optional
//            hold limit. A dead cycle separates consecutive owners so the
//            downstream mux never switches between two live owners on a
//            single edge.
// Ports    :
//   clk      in   1   single clock, rising edge
//   rst      in   1   synchronous active-high reset
//   req      in  16   level-sensitive request lines (bit i = mux input i)
//   grant    out 16   registered one-hot grant, or zero
//   sel      out  4   registered index of the current / most recent owner
//   busy     out  1   registered, high exactly when grant is non-zero
//   expired  out  1   one-cycle pulse when ownership ended on the hold limit
// Params   :
//   MAX_HOLD  max consecutive grant cycles per ownership, 0 = unlimited
//             (legal range 0..255)
// Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] C_MAX_HOLD = MAX_HOLD[7:0];
    localparam logic       C_HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [7:0] C_HCNT_SAT = 8'hFF;

    state_t      state_q,   state_d;
    logic [15:0] grant_q,   grant_d;
    logic [3:0]  sel_q,     sel_d;
    logic        busy_q,    busy_d;
    logic        expired_q, expired_d;
    logic [3:0]  ptr_q,     ptr_d;
    logic [7:0]  hcnt_q,    hcnt_d;

    // Rotating priority search: first set request at or above ptr_q,
    // wrapping 15 -> 0. The 4-bit sum wraps naturally.
    logic       win_found;
    logic [3:0] win_idx;

    always_comb begin
        logic [3:0] cand;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        expired_d = 1'b0;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                    grant_d = 16'h0001 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    hcnt_d  = 8'd1;
                    ptr_d   = win_idx + 4'd1;
                end
            end

            ST_GRANT: begin
                // A drop takes precedence over the hold limit, so a
                // coincident drop never reports expiry.
                if (!req[sel_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = 16'h0000;
                    busy_d  = 1'b0;
                end else if (C_HOLD_EN && (hcnt_q == C_MAX_HOLD)) begin
                    state_d   = ST_RELEASE;
                    grant_d   = 16'h0000;
                    busy_d    = 1'b0;
                    expired_d = 1'b1;
                end else if (hcnt_q != C_HCNT_SAT) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            ST_RELEASE: begin
                // Dead cycle; sel keeps pointing at the previous owner.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 16'h0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 16'h0000;
            sel_q     <= 4'd0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            ptr_q     <= 4'd0;
            hcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule
`default_nettype wire

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares one 16-way 1-bit multiplexer among 16 requesters. It grants the mux to one requester at a time and drives the mux select with the winner's index. Each grant lasts while that requester holds its request, bounded by an optional hold limit. A dead cycle separates consecutive owners, so the downstream mux never switches between two live owners in a single edge.

## Interface
- `MAX_HOLD`, default 16: maximum number of consecutive grant cycles per ownership; 0 means unlimited; legal range 0..255.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req` input, 16 bits: request lines; bit i is requester i (mux input in_i); level-sensitive.
- `grant` output, 16 bits: one-hot grant, or all-zero; registered.
- `sel` output, 4 bits: index of the current or most recent owner; connects to the mux `sel`; registered.
- `busy` output, 1 bit: high exactly when `grant` is non-zero.
- `expired` output, 1 bit: one-cycle pulse when an ownership ended because of `MAX_HOLD`.

## Operation
- **States:**
  - IDLE: no owner; arbitrates every cycle.
  - GRANT: one owner.
  - RELEASE: single dead cycle with `grant`=0.
- **Reset** (`rst` high at an edge, any state, including mid-grant):
  - state goes to IDLE; `grant`=0, `sel`=0, `busy`=0, `expired`=0.
  - priority pointer `ptr`=0; hold counter `hcnt`=0.
  - `rst` overrides all other inputs that cycle.
- **IDLE:**
  - If `req`=0, stay in IDLE and leave outputs unchanged (`sel` keeps its last value).
  - If any request is present, the winner is the first set bit found searching from index `ptr` upward, wrapping 15→0.
  - At the next edge: `grant`=one-hot(winner), `sel`=winner, `busy`=1, `hcnt`=1, state goes to GRANT.
  - `ptr`=(winner+1) mod 16, computed with 4-bit natural wrap.
- **GRANT:** evaluated at each edge, in this priority order:
  - `req[sel]`=0: go to RELEASE with `expired`=0.
  - else `MAX_HOLD`≠0 and `hcnt`==`MAX_HOLD`: go to RELEASE with `expired`=1.
  - else stay in GRANT; `hcnt` increments, saturating at 255.
  - Requests from other requesters never preempt the owner.
- **RELEASE:**
  - `grant`=0 and `busy`=0; `sel` holds the previous owner.
  - `expired` is high for this cycle only when set on entry.
  - The next edge always goes to IDLE.
  - Consequence: an expired owner that keeps requesting is re-arbitrated with lowest priority, because `ptr` has already moved past it.
- **Invariants:**
  - `grant` is either zero or one-hot, and when non-zero its set bit equals `sel`.
  - `busy` == |`grant`.
  - `expired` is never high outside RELEASE.

## Timing
- Request-to-grant latency is one cycle from IDLE: `req` sampled at edge N gives `grant` valid after edge N.
- Request drop ends the grant one edge later. `grant` stays 0 for exactly one cycle (RELEASE). The earliest regrant is two edges after the edge in GRANT that saw `req[sel]` low.
- With `MAX_HOLD`=M and a continuously held request, `grant` is high for exactly M cycles, then 1 RELEASE cycle, then 1 IDLE cycle, then the next grant.
- With a single continuous requester and `MAX_HOLD`=M, the period is M+2 cycles with M grant cycles.
- Simultaneous events in GRANT: a request drop on the same edge as the hold limit counts as a drop, so `expired`=0.
- All outputs are registered; there is no combinational path from `req` to any output.

## Test plan
- **Reset:** assert `rst` for 2 cycles while `req`=16'hFFFF.
  - Required: `grant`=0, `sel`=0, `busy`=0, `expired`=0.
  - On release of `rst`, the first grant is 16'h0001 one cycle later.
- **Round-robin fairness:** `MAX_HOLD`=4, `req`=16'h8421 held constant.
  - Required grant order: 0, 5, 10, 15, 0…
  - Each grant lasts 4 cycles with `expired`=1 pulses.
  - `sel` steps 0→5→10→15.
  - Gap between grants is 2 cycles.
- **Release by drop:** `req`=16'h0008 for 3 cycles, then 0.
  - Required: `grant`=16'h0008 for 3 cycles, then RELEASE, then IDLE.
  - `expired`=0 throughout; `sel` stays 3 afterwards.
- **Wrap-around:** after a grant to 15 completes, `req`=16'h0003.
  - Required: the next winner is 0 (the pointer wraps to 0), then 1.
- **Unlimited hold and no preemption:** `MAX_HOLD`=0, `req`=16'h0002 held for 300 cycles, with bit 9 raised at cycle 10.
  - Required: `grant`=16'h0002 for all 300 cycles, with no `expired` pulse.
  - Bit 9 is granted 2 cycles after bit 1 drops.
- **Reset mid-grant:** `rst` asserted during a GRANT to 7.
  - Required: the next cycle has all outputs 0 and `ptr`=0.
  - With `req`=16'h0081, the winner is 0.
